// File: rtl/fb_pkg.sv
// Shared framebuffer geometry constants and the arbiter FSM state encoding.
package fb_pkg;

    localparam int ADDR_W   = 19;
    localparam int DATA_W   = 4;
    localparam int FB_DEPTH = 307200;

    typedef enum logic [0:0] {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } arb_state_t;

endpackage

// File: rtl/fb_read_pipe.sv
// Scanout read return path: a read granted in cycle t comes back as
// rvalid/rdata in cycle t+2, lining up with the memory's one-cycle read latency.
module fb_read_pipe #(
    parameter int DATA_W = fb_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata
);

    logic stage1_q, stage1_d;
    logic stage2_q, stage2_d;

    always_comb begin
        stage1_d = issue;
        stage2_d = stage1_q;
    end

    // Clearing both stages on reset drops any read still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage1_q <= 1'b0;
            stage2_q <= 1'b0;
        end else begin
            stage1_q <= stage1_d;
            stage2_q <= stage2_d;
        end
    end

    assign rvalid = stage2_q;
    assign rdata  = stage2_q ? mem_rdata : '0;

endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter shared by scanout reads, vector-writer writes
// and a clear sequencer that only exists when built with FB_CLEAR_EN.
module fb_arbiter #(
    parameter int              ADDR_W     = fb_pkg::ADDR_W,
    parameter int              DATA_W     = fb_pkg::DATA_W,
    parameter int              FB_DEPTH   = fb_pkg::FB_DEPTH,
    parameter int              STARVE_MAX = 8,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scan_req,
    input  logic [ADDR_W-1:0] scan_addr,
    output logic              scan_gnt,
    output logic              scan_rvalid,
    output logic [DATA_W-1:0] scan_rdata,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    input  logic              clear_start,
    output logic              clear_done,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                starved;
    logic                scan_gnt_c, wr_gnt_c, clear_step;
    logic                in_clear;
    logic [ADDR_W-1:0]   step_addr;

    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

`ifdef FB_CLEAR_EN
    import fb_pkg::arb_state_t;
    import fb_pkg::ARB;
    import fb_pkg::CLEAR;

    arb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] clear_addr_q, clear_addr_d;
    logic              clear_last;

    assign in_clear  = (state_q == CLEAR);
    assign step_addr = clear_addr_q;

    // clear_start is only looked at in ARB, so a pulse during a clear is dropped.
    always_comb begin
        state_d      = state_q;
        clear_addr_d = clear_addr_q;
        clear_last   = 1'b0;
        if (in_clear) begin
            if (clear_step) begin
                if (clear_addr_q == ADDR_W'(FB_DEPTH - 1)) begin
                    clear_last   = 1'b1;
                    state_d      = ARB;
                    clear_addr_d = '0;
                end else begin
                    clear_addr_d = clear_addr_q + 1'b1;
                end
            end
        end else if (clear_start) begin
            state_d      = CLEAR;
            clear_addr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB;
            clear_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            clear_addr_q <= clear_addr_d;
        end
    end

    assign busy       = in_clear;
    assign clear_done = clear_last;
`else
    localparam int unused_fb_depth = FB_DEPTH;
    logic unused_clear_start;

    assign unused_clear_start = clear_start;
    assign in_clear           = 1'b0;
    assign step_addr          = '0;
    assign busy               = 1'b0;
    assign clear_done         = 1'b0;
`endif

    // Scanout has priority except when the writer has waited STARVE_MAX cycles;
    // during a clear the writer is locked out and the clear fills idle cycles.
    always_comb begin
        starved    = wr_req && (starve_cnt_q == STARVE_W'(STARVE_MAX));
        scan_gnt_c = 1'b0;
        wr_gnt_c   = 1'b0;
        clear_step = 1'b0;
        if (!rst) begin
            if (in_clear) begin
                scan_gnt_c = scan_req;
                clear_step = !scan_req;
            end else if (wr_req && (starved || !scan_req)) begin
                wr_gnt_c = 1'b1;
            end else begin
                scan_gnt_c = scan_req;
            end
        end
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!wr_req || wr_gnt_c) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != STARVE_W'(STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_comb begin
        mem_en_d    = scan_gnt_c | wr_gnt_c | clear_step;
        mem_we_d    = wr_gnt_c | clear_step;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        if (wr_gnt_c) begin
            mem_addr_d  = wr_addr;
            mem_wdata_d = wr_data;
        end else if (clear_step) begin
            mem_addr_d  = step_addr;
            mem_wdata_d = CLEAR_VAL;
        end else if (scan_gnt_c) begin
            mem_addr_d  = scan_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    fb_read_pipe #(
        .DATA_W (DATA_W)
    ) u_read_pipe (
        .clk       (clk),
        .rst       (rst),
        .issue     (scan_gnt_c),
        .mem_rdata (mem_rdata),
        .rvalid    (scan_rvalid),
        .rdata     (scan_rdata)
    );

    assign scan_gnt  = scan_gnt_c;
    assign wr_gnt    = wr_gnt_c;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter; the clear scenarios run only when FB_CLEAR_EN
// is defined, otherwise the bench checks that clear_start is ignored.
module tb_fb_arbiter;

    localparam int ADDR_W     = 19;
    localparam int DATA_W     = 4;
    localparam int TB_DEPTH   = 2048;
    localparam int STARVE_MAX = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              scan_req;
    logic [ADDR_W-1:0] scan_addr;
    logic              scan_gnt;
    logic              scan_rvalid;
    logic [DATA_W-1:0] scan_rdata;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_gnt;
    logic              clear_start;
    logic              clear_done;
    logic              busy;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;

    fb_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .FB_DEPTH   (TB_DEPTH),
        .STARVE_MAX (STARVE_MAX),
        .CLEAR_VAL  (4'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .scan_req    (scan_req),
        .scan_addr   (scan_addr),
        .scan_gnt    (scan_gnt),
        .scan_rvalid (scan_rvalid),
        .scan_rdata  (scan_rdata),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_gnt      (wr_gnt),
        .clear_start (clear_start),
        .clear_done  (clear_done),
        .busy        (busy),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory stub: read data is a fixed pattern of the address, one cycle late.
    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= mem_addr[3:0] ^ mem_addr[7:4] ^ 4'h5;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic s_req, input logic [ADDR_W-1:0] s_addr,
                                 input logic w_req, input logic [ADDR_W-1:0] w_addr,
                                 input logic [DATA_W-1:0] w_data, input logic c_start);
        @(negedge clk);
        scan_req    = s_req;
        scan_addr   = s_addr;
        wr_req      = w_req;
        wr_addr     = w_addr;
        wr_data     = w_data;
        clear_start = c_start;
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_scan_gnt"},    32'(scan_gnt),    32'h0);
        checkOutput({tag, "_wr_gnt"},      32'(wr_gnt),      32'h0);
        checkOutput({tag, "_scan_rvalid"}, 32'(scan_rvalid), 32'h0);
        checkOutput({tag, "_scan_rdata"},  32'(scan_rdata),  32'h0);
        checkOutput({tag, "_clear_done"},  32'(clear_done),  32'h0);
        checkOutput({tag, "_busy"},        32'(busy),        32'h0);
        checkOutput({tag, "_mem_en"},      32'(mem_en),      32'h0);
        checkOutput({tag, "_mem_we"},      32'(mem_we),      32'h0);
        checkOutput({tag, "_mem_addr"},    32'(mem_addr),    32'h0);
        checkOutput({tag, "_mem_wdata"},   32'(mem_wdata),   32'h0);
    endtask

    initial begin
        logic [17:0] wr_vec;
        logic [17:0] scan_vec;
        int writes, good, done_cnt, done_idx, busy_cnt, exp_addr, wr_in_clear, scan_in_clear;
        logic prev_busy;

        rst = 1'b1;
        scan_req = 1'b0; scan_addr = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0; clear_start = 1'b0;

        $display("[TB] reset");
        repeat (3) applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
        checkAllZero("reset");
        applyStimulus(1'b1, 19'h00100, 1'b1, 19'h00005, 4'h1, 1'b1);
        checkOutput("rst_scan_gnt", 32'(scan_gnt), 32'h0);
        checkOutput("rst_wr_gnt",   32'(wr_gnt),   32'h0);
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;

        $display("[TB] scan reads");
        applyStimulus(1'b1, 19'h00100, 1'b0, '0, '0, 1'b0);
        checkOutput("rd0_scan_gnt", 32'(scan_gnt), 32'h1);
        checkOutput("rd0_wr_gnt",   32'(wr_gnt),   32'h0);
        applyStimulus(1'b1, 19'h0003C, 1'b0, '0, '0, 1'b0);
        checkOutput("rd1_scan_gnt", 32'(scan_gnt),    32'h1);
        checkOutput("rd0_mem_en",   32'(mem_en),      32'h1);
        checkOutput("rd0_mem_we",   32'(mem_we),      32'h0);
        checkOutput("rd0_mem_addr", 32'(mem_addr),    32'h00100);
        checkOutput("rd0_early",    32'(scan_rvalid), 32'h0);
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
        checkOutput("rd1_mem_addr", 32'(mem_addr),    32'h0003C);
        checkOutput("rd0_rvalid",   32'(scan_rvalid), 32'h1);
        checkOutput("rd0_rdata",    32'(scan_rdata),  32'h5);
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
        checkOutput("rd1_rvalid",   32'(scan_rvalid), 32'h1);
        checkOutput("rd1_rdata",    32'(scan_rdata),  32'hA);
        checkOutput("idle_mem_en",  32'(mem_en),      32'h0);
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
        checkOutput("rd_done_rvalid", 32'(scan_rvalid), 32'h0);

        $display("[TB] writer");
        applyStimulus(1'b0, '0, 1'b1, 19'h4AFFF, 4'hA, 1'b0);
        checkOutput("wr_gnt",        32'(wr_gnt),   32'h1);
        checkOutput("wr_no_scan",    32'(scan_gnt), 32'h0);
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
        checkOutput("wr_mem_en",    32'(mem_en),    32'h1);
        checkOutput("wr_mem_we",    32'(mem_we),    32'h1);
        checkOutput("wr_mem_addr",  32'(mem_addr),  32'h4AFFF);
        checkOutput("wr_mem_wdata", 32'(mem_wdata), 32'hA);

        $display("[TB] starvation");
        wr_vec = '0;
        scan_vec = '0;
        for (int i = 0; i < 18; i++) begin
            applyStimulus(1'b1, 19'h00200, 1'b1, 19'h00300, 4'h3, 1'b0);
            wr_vec[i]   = wr_gnt;
            scan_vec[i] = scan_gnt;
        end
        checkOutput("starve_wr_pattern",   32'(wr_vec),   32'h20100);
        checkOutput("starve_scan_pattern", 32'(scan_vec), 32'h1FEFF);
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);

        // A read issued just before reset must never come back.
        applyStimulus(1'b1, 19'h00010, 1'b0, '0, '0, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
        rst = 1'b0;
        checkOutput("flush_rvalid_a", 32'(scan_rvalid), 32'h0);
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
        checkOutput("flush_rvalid_b", 32'(scan_rvalid), 32'h0);

`ifdef FB_CLEAR_EN
        $display("[TB] clear, idle bus");
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1);
        checkOutput("clr_start_busy", 32'(busy), 32'h0);
        writes = 0; good = 0; done_cnt = 0; done_idx = -1; busy_cnt = 0; exp_addr = 0; prev_busy = 1'b0;
        for (int n = 0; n < TB_DEPTH + 5; n++) begin
            applyStimulus(1'b0, '0, 1'b0, '0, '0, n == 100);
            if (prev_busy && mem_en && mem_we) begin
                writes++;
                if (mem_addr == ADDR_W'(exp_addr) && mem_wdata == 4'h0) good++;
                exp_addr++;
            end
            if (clear_done) begin done_cnt++; done_idx = n; end
            if (busy) busy_cnt++;
            prev_busy = busy;
        end
        checkOutput("clr_writes",    32'(writes),   32'(TB_DEPTH));
        checkOutput("clr_addr_ok",   32'(good),     32'(TB_DEPTH));
        checkOutput("clr_done_cnt",  32'(done_cnt), 32'h1);
        checkOutput("clr_done_idx",  32'(done_idx), 32'(TB_DEPTH - 1));
        checkOutput("clr_busy_cnt",  32'(busy_cnt), 32'(TB_DEPTH));
        checkOutput("clr_busy_end",  32'(busy),     32'h0);

        $display("[TB] clear, scan every 2nd cycle");
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1);
        writes = 0; good = 0; done_cnt = 0; done_idx = -1; busy_cnt = 0; exp_addr = 0; prev_busy = 1'b0;
        wr_in_clear = 0; scan_in_clear = 0;
        for (int n = 0; n < 2 * TB_DEPTH + 5; n++) begin
            applyStimulus((n % 2) == 0, 19'h00007, 1'b1, 19'h00300, 4'h3, 1'b0);
            if (busy && wr_gnt) wr_in_clear++;
            if (busy && scan_gnt) scan_in_clear++;
            if (prev_busy && mem_en && mem_we) begin
                writes++;
                if (mem_addr == ADDR_W'(exp_addr) && mem_wdata == 4'h0) good++;
                exp_addr++;
            end
            if (clear_done) begin done_cnt++; done_idx = n; end
            if (busy) busy_cnt++;
            prev_busy = busy;
        end
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
        checkOutput("clr2_writes",   32'(writes),        32'(TB_DEPTH));
        checkOutput("clr2_addr_ok",  32'(good),          32'(TB_DEPTH));
        checkOutput("clr2_wr_gnt",   32'(wr_in_clear),   32'h0);
        checkOutput("clr2_scan_gnt", 32'(scan_in_clear), 32'(TB_DEPTH));
        checkOutput("clr2_busy_cnt", 32'(busy_cnt),      32'(2 * TB_DEPTH));
        checkOutput("clr2_done_idx", 32'(done_idx),      32'(2 * TB_DEPTH - 1));
        checkOutput("clr2_done_cnt", 32'(done_cnt),      32'h1);

        $display("[TB] reset mid-clear");
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1);
        done_cnt = 0;
        for (int n = 0; n < 1000; n++) begin
            applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
            if (clear_done) done_cnt++;
        end
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("midrst_last_addr", 32'(mem_addr),   32'd999);
        checkOutput("midrst_busy",      32'(busy),       32'h1);
        checkOutput("midrst_done",      32'(clear_done), 32'h0);
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
        checkAllZero("midrst");
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
            if (clear_done) done_cnt++;
        end
        checkOutput("midrst_no_done",  32'(done_cnt), 32'h0);
        checkOutput("midrst_idle",     32'(busy),     32'h0);
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
        checkOutput("restart_busy",    32'(busy),     32'h1);
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
        checkOutput("restart_we",      32'(mem_we),   32'h1);
        checkOutput("restart_addr0",   32'(mem_addr), 32'h0);
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
        checkOutput("restart_addr1",   32'(mem_addr), 32'h1);
        rst = 1'b1;
        repeat (2) applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
        rst = 1'b0;
`else
        $display("[TB] clear_start ignored");
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1);
        checkOutput("noclr_busy", 32'(busy),       32'h0);
        checkOutput("noclr_done", 32'(clear_done), 32'h0);
        applyStimulus(1'b0, '0, 1'b1, 19'h00010, 4'h7, 1'b0);
        checkOutput("noclr_busy2",  32'(busy),   32'h0);
        checkOutput("noclr_wr_gnt", 32'(wr_gnt), 32'h1);
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
        checkOutput("noclr_done2",   32'(clear_done), 32'h0);
        checkOutput("noclr_mem_we",  32'(mem_we),     32'h1);
        checkOutput("noclr_mem_addr", 32'(mem_addr),  32'h00010);
        checkOutput("noclr_mem_wdata", 32'(mem_wdata), 32'h7);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
